// File: rtl/joypad_serial_poller_if.sv
// ---------------------------------------------------------------------------
// joypad_serial_poller_if
// Bundles the pad-side serial lines and the host-side button outputs of the
// joypad poller.
//   poll_en     : host -> poller, enables frame starts on the poll tick
//   pad_data    : pad  -> poller, serial button data, active-low
//   pad_latch   : poller -> pad, latch strobe, active-high
//   pad_clk     : poller -> pad, shift clock, idles high
//   buttons     : poller -> host, button vector, active-low
//   frame_valid : poller -> host, one-cycle pulse on buttons update
//   joy_irq     : poller -> host, one-cycle pulse on any press edge
// Modports: slave = the poller, master = the surrounding environment.
// ---------------------------------------------------------------------------
interface joypad_serial_poller_if;
    logic       poll_en;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] buttons;
    logic       frame_valid;
    logic       joy_irq;

    modport master (
        output poll_en, pad_data,
        input  pad_latch, pad_clk, buttons, frame_valid, joy_irq
    );

    modport slave (
        input  poll_en, pad_data,
        output pad_latch, pad_clk, buttons, frame_valid, joy_irq
    );
endinterface

// File: rtl/joypad_serial_poller.sv
// ---------------------------------------------------------------------------
// joypad_serial_poller
// Polls an NES-style serial gamepad (latch / clock / data) at a fixed rate
// and rebuilds the 8-bit active-low button vector used by the FF00 joypad
// register: buttons[3:0] = right, left, up, down; buttons[7:4] = a, b,
// select, start. Raises a one-cycle joy_irq when any button becomes pressed.
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : joypad_serial_poller_if.slave (poll_en, pad_data in; pad_latch,
//           pad_clk, buttons, frame_valid, joy_irq out)
//
// Optional build macro JOYPAD_DEBOUNCE_EN: buttons/joy_irq only follow a raw
// frame that matches the previous raw frame; frame_valid still pulses on
// every frame.
// ---------------------------------------------------------------------------
module joypad_serial_poller #(
    parameter int unsigned LATCH_CYCLES = 1200,
    parameter int unsigned HALF_CYCLES  = 600,
    parameter int unsigned POLL_CYCLES  = 1666667
) (
    input  logic                   clk,
    input  logic                   rst_n,
    joypad_serial_poller_if.slave  bus
);

    localparam int unsigned CMAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned PW   = $clog2(POLL_CYCLES + 1);

    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);
    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SETTLE,
        S_SAMPLE,
        S_CLK_LO,
        S_CLK_HI,
        S_UPDATE
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [1:0]    pad_sync;
    logic [PW-1:0] poll_cnt;
    logic          tick;
    logic          tick_pending;
    logic          start_ok;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    frame_new;
    logic          pad_latch_q;
    logic          pad_clk_q;
    logic [7:0]    buttons_q;
    logic          frame_valid_q;
    logic          joy_irq_q;
`ifdef JOYPAD_DEBOUNCE_EN
    logic [7:0]    prev_raw;
`endif

    // Tick marks the cycle whose edge wraps the poll counter back to 0.
    assign tick     = (poll_cnt == POLL_LAST);
    assign start_ok = bus.poll_en && (tick || tick_pending);

    // Serial order A,B,Select,Start,Up,Down,Left,Right -> buttons bit order.
    assign frame_new = {shift[3], shift[2], shift[1], shift[0],
                        shift[5], shift[4], shift[6], shift[7]};

    assign bus.pad_latch   = pad_latch_q;
    assign bus.pad_clk     = pad_clk_q;
    assign bus.buttons     = buttons_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.joy_irq     = joy_irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start_ok) state_nx = S_LATCH;
            S_LATCH:  if (cnt == LATCH_LAST) state_nx = S_SETTLE;
            S_SETTLE: if (cnt == HALF_LAST) state_nx = S_SAMPLE;
            S_SAMPLE: state_nx = (bit_idx == 3'd7) ? S_UPDATE : S_CLK_LO;
            S_CLK_LO: if (cnt == HALF_LAST) state_nx = S_CLK_HI;
            S_CLK_HI: if (cnt == HALF_LAST) state_nx = S_SAMPLE;
            S_UPDATE: state_nx = start_ok ? S_LATCH : S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_sync      <= 2'b11;
            poll_cnt      <= '0;
            tick_pending  <= 1'b0;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '1;
            pad_latch_q   <= 1'b0;
            pad_clk_q     <= 1'b1;
            buttons_q     <= '1;
            frame_valid_q <= 1'b0;
            joy_irq_q     <= 1'b0;
`ifdef JOYPAD_DEBOUNCE_EN
            prev_raw      <= '1;
`endif
        end else begin
            pad_sync <= {pad_sync[0], bus.pad_data};
            poll_cnt <= tick ? '0 : poll_cnt + PW'(1);

            // Pad lines are registered from the next state so they line up
            // with the state register and never glitch.
            pad_latch_q <= (state_nx == S_LATCH);
            pad_clk_q   <= (state_nx != S_CLK_LO);

            cnt <= (state_nx != state) ? '0 : cnt + CW'(1);

            if (state != S_LATCH && state_nx == S_LATCH) begin
                tick_pending <= 1'b0;
            end else if (tick && state != S_IDLE) begin
                tick_pending <= 1'b1;
            end else if (state == S_IDLE && !bus.poll_en) begin
                tick_pending <= 1'b0;
            end

            if (state == S_LATCH) begin
                bit_idx <= '0;
            end else if (state == S_CLK_HI && state_nx == S_SAMPLE) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (state == S_SAMPLE) begin
                shift[bit_idx] <= pad_sync[1];
            end

            frame_valid_q <= 1'b0;
            joy_irq_q     <= 1'b0;
            if (state == S_UPDATE) begin
                frame_valid_q <= 1'b1;
`ifdef JOYPAD_DEBOUNCE_EN
                prev_raw <= frame_new;
                if (frame_new == prev_raw) begin
                    buttons_q <= frame_new;
                    joy_irq_q <= |(buttons_q & ~frame_new);
                end
`else
                buttons_q <= frame_new;
                joy_irq_q <= |(buttons_q & ~frame_new);
`endif
            end
        end
    end

endmodule

// File: tb/tb_joypad_serial_poller.sv
// ---------------------------------------------------------------------------
// tb_joypad_serial_poller
// Directed bench for joypad_serial_poller with LATCH_CYCLES=8, HALF_CYCLES=4,
// POLL_CYCLES=200. A small pad model loads an 8-bit serial frame on latch
// and shifts on each pad_clk rising edge; monitors count latch/clock pulses
// and irq pulses. Expectations follow JOYPAD_DEBOUNCE_EN when defined.
// ---------------------------------------------------------------------------
module tb_joypad_serial_poller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    joypad_serial_poller_if bus();

    joypad_serial_poller #(
        .LATCH_CYCLES(8),
        .HALF_CYCLES (4),
        .POLL_CYCLES (200)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pad model: bit i of pad_frame is serial element i (A first), active-low.
    logic [7:0] pad_frame = 8'hFF;
    logic [7:0] pad_sr = 8'hFF;
    logic       pad_clk_p = 1'b1;

    always @(posedge clk) begin
        pad_clk_p <= bus.pad_clk;
        if (bus.pad_latch) pad_sr <= pad_frame;
        else if (bus.pad_clk && !pad_clk_p) pad_sr <= {1'b1, pad_sr[7:1]};
    end
    assign bus.pad_data = pad_sr[0];

    // Monitors sampled on the falling edge.
    int unsigned cyc = 0;
    int unsigned latch_rises = 0, latch_rise_cyc = 0, latch_run = 0, last_latch_len = 0;
    int unsigned clk_run = 0, clk_pulses = 0, clk_lo_wrong = 0;
    int unsigned irq_cnt = 0, fv_cnt = 0, fv_cyc = 0;
    logic        latch_d = 1'b0, clk_d = 1'b1;

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        latch_d <= bus.pad_latch;
        clk_d   <= bus.pad_clk;
        if (bus.pad_latch && !latch_d) begin
            latch_rises    <= latch_rises + 1;
            latch_rise_cyc <= cyc;
        end
        if (bus.pad_latch) latch_run <= latch_run + 1;
        else begin
            if (latch_d) last_latch_len <= latch_run;
            latch_run <= 0;
        end
        if (!bus.pad_clk) clk_run <= clk_run + 1;
        else begin
            if (!clk_d) begin
                clk_pulses <= clk_pulses + 1;
                if (clk_run != 4) clk_lo_wrong <= clk_lo_wrong + 1;
            end
            clk_run <= 0;
        end
        if (bus.joy_irq) irq_cnt <= irq_cnt + 1;
        if (bus.frame_valid) begin
            fv_cnt <= fv_cnt + 1;
            fv_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fv(input int unsigned limit, output logic ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.frame_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_latch(input int unsigned limit, output logic ok, output int unsigned n);
        ok = 1'b0;
        n  = 0;
        for (int unsigned i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (bus.pad_latch) begin
                ok = 1'b1;
                n  = i;
                break;
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] serial, input logic [7:0] exp_btn, input logic exp_irq);
        int unsigned i0, p0, w0;
        logic ok;
        pad_frame = serial;
        i0 = irq_cnt;
        p0 = clk_pulses;
        w0 = clk_lo_wrong;
        wait_fv(450, ok);
        check("frame_valid_seen", ok, 1'b1);
        check("buttons", bus.buttons, exp_btn);
        check("joy_irq_at_fv", bus.joy_irq, exp_irq);
        @(negedge clk);
        check("frame_valid_one_cycle", bus.frame_valid, 1'b0);
        check("irq_pulses_in_frame", irq_cnt - i0, exp_irq);
        check("pad_clk_pulses", clk_pulses - p0, 7);
        check("pad_clk_low_len_bad", clk_lo_wrong - w0, 0);
        check("latch_len", last_latch_len, 8);
    endtask

`ifdef JOYPAD_DEBOUNCE_EN
    logic [7:0] model_btn = 8'hFF;
`endif

    // Debounced builds need each pattern twice: the first frame only primes
    // the previous-raw store and leaves buttons unchanged.
    task automatic send(input logic [7:0] serial, input logic [7:0] exp_btn, input logic exp_irq);
`ifdef JOYPAD_DEBOUNCE_EN
        run_frame(serial, model_btn, 1'b0);
        model_btn = exp_btn;
`endif
        run_frame(serial, exp_btn, exp_irq);
    endtask

    initial begin
        logic        ok;
        int unsigned n, l0, f0, p0, falls;
        logic        prev_clk;

        bus.poll_en = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_pad_clk", bus.pad_clk, 1'b1);
        check("rst_pad_latch", bus.pad_latch, 1'b0);
        check("rst_buttons", bus.buttons, 8'hFF);
        check("rst_frame_valid", bus.frame_valid, 1'b0);
        check("rst_joy_irq", bus.joy_irq, 1'b0);
        rst_n = 1'b1;

        // Idle pad, then single buttons, all, none, and mixed patterns.
        send(8'hFF, 8'hFF, 1'b0);
        check("frame_length", fv_cyc - latch_rise_cyc, 77);
        send(8'hFE, 8'hEF, 1'b1);   // A
        send(8'h7F, 8'hFE, 1'b1);   // Right
        send(8'h00, 8'h00, 1'b1);   // all pressed
        send(8'hFF, 8'hFF, 1'b0);   // all released
        send(8'hA7, 8'h79, 1'b1);   // Start, Up, Left
        send(8'hD9, 8'h97, 1'b1);   // B, Select, Down
        send(8'hFF, 8'hFF, 1'b0);

        // poll_en dropped mid-frame: the frame completes, then no more frames.
        pad_frame = 8'hFE;
        wait_latch(300, ok, n);
        check("poll_frame_start", ok, 1'b1);
        repeat (20) @(negedge clk);
        bus.poll_en = 1'b0;
        wait_fv(200, ok);
        check("poll_off_frame_done", ok, 1'b1);
`ifdef JOYPAD_DEBOUNCE_EN
        check("poll_off_buttons", bus.buttons, 8'hFF);
        check("poll_off_irq", bus.joy_irq, 1'b0);
`else
        check("poll_off_buttons", bus.buttons, 8'hEF);
        check("poll_off_irq", bus.joy_irq, 1'b1);
`endif
        @(negedge clk);
        l0 = latch_rises;
        f0 = fv_cnt;
        repeat (700) @(negedge clk);
        check("poll_off_no_latch", latch_rises - l0, 0);
        check("poll_off_no_frame", fv_cnt - f0, 0);
        bus.poll_en = 1'b1;
        wait_latch(201, ok, n);
        check("poll_resume_latch", ok, 1'b1);
`ifdef JOYPAD_DEBOUNCE_EN
        run_frame(8'hFE, 8'hEF, 1'b1);
`else
        run_frame(8'hFE, 8'hEF, 1'b0);
`endif

        // Reset during the pad_clk low phase that follows bit 3.
        wait_latch(300, ok, n);
        check("rst_test_latch", ok, 1'b1);
        falls = 0;
        prev_clk = 1'b1;
        for (int unsigned i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.pad_clk && prev_clk) falls++;
            prev_clk = bus.pad_clk;
            if (falls == 4) break;
        end
        check("rst_test_fourth_low", falls, 4);
        @(negedge clk);
        check("pre_reset_buttons", bus.buttons, 8'hEF);
        check("pre_reset_pad_clk", bus.pad_clk, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pad_clk", bus.pad_clk, 1'b1);
        check("mid_rst_pad_latch", bus.pad_latch, 1'b0);
        check("mid_rst_buttons", bus.buttons, 8'hFF);
        check("mid_rst_frame_valid", bus.frame_valid, 1'b0);
        check("mid_rst_joy_irq", bus.joy_irq, 1'b0);
        repeat (3) @(negedge clk);
        pad_frame = 8'hFF;
        rst_n = 1'b1;
        p0 = clk_pulses;
        wait_latch(260, ok, n);
        check("post_rst_latch_seen", ok, 1'b1);
        check("post_rst_latch_delay", n, 200);
        check("post_rst_no_clk_before_latch", clk_pulses - p0, 0);
        run_frame(8'hFF, 8'hFF, 1'b0);

        // Glitch filter sequence FF, EF, FF, EF, EF (buttons view).
`ifdef JOYPAD_DEBOUNCE_EN
        run_frame(8'hFF, 8'hFF, 1'b0);
        run_frame(8'hFE, 8'hFF, 1'b0);
        run_frame(8'hFF, 8'hFF, 1'b0);
        run_frame(8'hFE, 8'hFF, 1'b0);
        run_frame(8'hFE, 8'hEF, 1'b1);
`else
        run_frame(8'hFF, 8'hFF, 1'b0);
        run_frame(8'hFE, 8'hEF, 1'b1);
        run_frame(8'hFF, 8'hFF, 1'b0);
        run_frame(8'hFE, 8'hEF, 1'b1);
        run_frame(8'hFE, 8'hEF, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
